audio_sample_scheduler: RTL and testbench

//  Schedules stereo PCM delivery to the hdmi core from the clk_pixel domain. A fractional

---
 rtl/audio_sample_scheduler.sv | 145 ++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler
// Generates an exact-average AUDIO_RATE strobe in the clk_pixel domain using a
// fractional accumulator. It buffers stereo pairs from a valid/ready source in
// a small FIFO, and presents one arithmetically attenuated pair on each strobe.
// Ticks that find the FIFO empty are counted as underruns (saturating).
module audio_sample_scheduler #(
    parameter int PIXEL_CLK_HZ    = 74250000,
    parameter int AUDIO_RATE      = 48000,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int ATTEN_SHIFT     = 9
) (
    input  logic                          clk_pixel,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic [AUDIO_BIT_WIDTH-1:0]    src_left,
    input  logic [AUDIO_BIT_WIDTH-1:0]    src_right,
    output logic                          audio_tick,
    output logic [AUDIO_BIT_WIDTH-1:0]    audio_left,
    output logic [AUDIO_BIT_WIDTH-1:0]    audio_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_count
);

    // The accumulator must hold acc + AUDIO_RATE without wrapping.
    // acc stays below PIXEL_CLK_HZ, so one extra bit is enough.
    localparam int ACC_W = $clog2(PIXEL_CLK_HZ) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [ACC_W-1:0] RATE_C  = ACC_W'(AUDIO_RATE);
    localparam logic [ACC_W-1:0] PIX_C   = ACC_W'(PIXEL_CLK_HZ);
    localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(FIFO_DEPTH);

    logic [ACC_W-1:0]           acc;
    logic [ACC_W-1:0]           acc_sum;
    logic [ACC_W-1:0]           acc_next;
    logic                       tick_next;

    logic [AUDIO_BIT_WIDTH-1:0] mem_left  [FIFO_DEPTH];
    logic [AUDIO_BIT_WIDTH-1:0] mem_right [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [LVL_W-1:0]           level_next;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       push;
    logic                       pop;
    logic                       underrun;

    // Source handshake: a pair transfers on a rising clk_pixel edge where both
    // src_valid and src_ready are high. src_valid may assert at any time.
    // src_ready depends only on enable, reset and the registered level, never
    // on src_valid. A full FIFO refuses the pair even when a pop happens on the
    // same edge.

    // Tick decision, FIFO status and handshake qualifiers
    always_comb begin
        acc_sum    = acc + RATE_C;
        tick_next  = enable && (acc_sum >= PIX_C);
        acc_next   = tick_next ? (acc_sum - PIX_C) : acc_sum;
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == DEPTH_C);
        src_ready  = reset_n && enable && !fifo_full;
        push       = src_valid && src_ready;
        pop        = tick_next && !fifo_empty;
        underrun   = tick_next && fifo_empty;
    end

    // Occupancy after this edge's push and pop
    always_comb begin
        level_next = fifo_level;
        if (push && !pop) begin
            level_next = fifo_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = fifo_level - LVL_W'(1);
        end
    end

    // Fractional accumulator and the one-cycle audio strobe
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            audio_tick <= 1'b0;
        end else if (!enable) begin
            acc        <= '0;
            audio_tick <= 1'b0;
        end else begin
            acc        <= acc_next;
            audio_tick <= tick_next;
        end
    end

    // FIFO pointers and level; disabling flushes the queue
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (!enable) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_next;
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem_left[wr_ptr]  <= src_left;
            mem_right[wr_ptr] <= src_right;
        end
    end

    // Output pair loads the attenuated head on a tick and holds otherwise
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else if (pop) begin
            audio_left  <= $signed(mem_left[rd_ptr]) >>> ATTEN_SHIFT;
            audio_right <= $signed(mem_right[rd_ptr]) >>> ATTEN_SHIFT;
        end
    end

    // Saturating count of ticks that found nothing to play
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: one instance at default rates (ATTEN_SHIFT=9)
// and one small-rate instance (50 Hz clock, 7 Hz strobe, ATTEN_SHIFT=0) for
// order, collision and cadence scenarios. Expected pairs are queued when a push
// is accepted; per-instance monitors pop and compare on every audio_tick.
module tb_audio_sample_scheduler;

    localparam int S_PIX  = 50;
    localparam int S_RATE = 7;

    // ---------------- clock / reset ----------------
    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    logic        rst_n_d     = 1'b0;
    logic        enable_d    = 1'b1;
    logic        src_valid_d = 1'b0;
    logic [15:0] src_left_d  = 16'h0;
    logic [15:0] src_right_d = 16'h0;
    logic        src_ready_d;
    logic        tick_d;
    logic [15:0] left_d;
    logic [15:0] right_d;
    logic [2:0]  level_d;
    logic [15:0] ur_d;

    logic        rst_n_s     = 1'b0;
    logic        enable_s    = 1'b1;
    logic        src_valid_s = 1'b0;
    logic [15:0] src_left_s  = 16'h0;
    logic [15:0] src_right_s = 16'h0;
    logic        src_ready_s;
    logic        tick_s;
    logic [15:0] left_s;
    logic [15:0] right_s;
    logic [2:0]  level_s;
    logic [15:0] ur_s;

    audio_sample_scheduler u_dut_d (
        .clk_pixel      (clk_pixel),
        .reset_n        (rst_n_d),
        .enable         (enable_d),
        .src_valid      (src_valid_d),
        .src_ready      (src_ready_d),
        .src_left       (src_left_d),
        .src_right      (src_right_d),
        .audio_tick     (tick_d),
        .audio_left     (left_d),
        .audio_right    (right_d),
        .fifo_level     (level_d),
        .underrun_count (ur_d)
    );

    audio_sample_scheduler #(
        .PIXEL_CLK_HZ (S_PIX),
        .AUDIO_RATE   (S_RATE),
        .ATTEN_SHIFT  (0)
    ) u_dut_s (
        .clk_pixel      (clk_pixel),
        .reset_n        (rst_n_s),
        .enable         (enable_s),
        .src_valid      (src_valid_s),
        .src_ready      (src_ready_s),
        .src_left       (src_left_s),
        .src_right      (src_right_s),
        .audio_tick     (tick_s),
        .audio_left     (left_s),
        .audio_right    (right_s),
        .fifo_level     (level_s),
        .underrun_count (ur_s)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q_d[$];
    logic [31:0] exp_q_s[$];
    logic [31:0] last_d   = 32'h0;
    logic [31:0] last_s   = 32'h0;
    logic [15:0] exp_ur_d = 16'h0;
    logic [15:0] exp_ur_s = 16'h0;
    int          cyc_s    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Enabled-edge counter for the small instance, used to aim pushes at tick edges
    always @(posedge clk_pixel) begin
        if (!rst_n_s || !enable_s) cyc_s <= 0;
        else cyc_s <= cyc_s + 1;
    end

    function automatic bit is_tick_s(input int k);
        return ((S_RATE * k) / S_PIX) != ((S_RATE * (k - 1)) / S_PIX);
    endfunction

    // ---------------- monitors ----------------
    always @(posedge clk_pixel) begin
        #1;
        if (tick_d === 1'b1) begin
            if (exp_q_d.size() > 0) last_d = exp_q_d.pop_front();
            else if (exp_ur_d != 16'hFFFF) exp_ur_d = exp_ur_d + 16'd1;
            check("d_left", 32'(left_d), 32'(last_d[31:16]));
            check("d_right", 32'(right_d), 32'(last_d[15:0]));
            check("d_underrun", 32'(ur_d), 32'(exp_ur_d));
        end
    end

    always @(posedge clk_pixel) begin
        #1;
        if (tick_s === 1'b1) begin
            if (exp_q_s.size() > 0) last_s = exp_q_s.pop_front();
            else if (exp_ur_s != 16'hFFFF) exp_ur_s = exp_ur_s + 16'd1;
            check("s_left", 32'(left_s), 32'(last_s[31:16]));
            check("s_right", 32'(right_s), 32'(last_s[15:0]));
            check("s_underrun", 32'(ur_s), 32'(exp_ur_s));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tick_d(input int bound, output int edges);
        edges = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk_pixel);
            #1;
            if (tick_d === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic wait_tick_s(input int bound, output int edges);
        edges = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk_pixel);
            #1;
            if (tick_s === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic drive_d(input logic [15:0] l, input logic [15:0] r,
                           input logic [15:0] el, input logic [15:0] er);
        logic ok;
        ok = 1'b0;
        src_valid_d = 1'b1;
        src_left_d  = l;
        src_right_d = r;
        for (int k = 0; k < 100; k++) begin
            #1 ok = (src_ready_d === 1'b1);
            @(posedge clk_pixel);
            if (ok) break;
            @(negedge clk_pixel);
        end
        @(negedge clk_pixel);
        src_valid_d = 1'b0;
        check("d_push_accept", 32'(ok), 32'd1);
        if (ok) exp_q_d.push_back({el, er});
    endtask

    task automatic drive_s(input logic [15:0] l, input logic [15:0] r,
                           input logic [15:0] el, input logic [15:0] er,
                           input bit aligned);
        logic ok;
        ok = 1'b0;
        if (aligned) begin
            for (int k = 0; k < 20 && !is_tick_s(cyc_s + 1); k++) @(negedge clk_pixel);
        end
        src_valid_s = 1'b1;
        src_left_s  = l;
        src_right_s = r;
        for (int k = 0; k < 100; k++) begin
            #1 ok = (src_ready_s === 1'b1);
            @(posedge clk_pixel);
            if (ok) break;
            @(negedge clk_pixel);
        end
        @(negedge clk_pixel);
        src_valid_s = 1'b0;
        check("s_push_accept", 32'(ok), 32'd1);
        if (ok) exp_q_s.push_back({el, er});
    endtask

    // ---------------- default-rate scenarios ----------------
    task automatic run_d();
        int n;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        check("d_rst_tick", 32'(tick_d), 32'd0);
        check("d_rst_left", 32'(left_d), 32'd0);
        check("d_rst_right", 32'(right_d), 32'd0);
        check("d_rst_level", 32'(level_d), 32'd0);
        check("d_rst_underrun", 32'(ur_d), 32'd0);
        check("d_rst_ready", 32'(src_ready_d), 32'd0);
        rst_n_d = 1'b1;

        wait_tick_d(2000, n);
        check("d_first_tick_edge", 32'(n), 32'd1547);
        @(posedge clk_pixel);
        #1;
        check("d_tick_width", 32'(tick_d), 32'd0);
        wait_tick_d(2000, n);
        check("d_interval", 32'((n + 1 == 1546) || (n + 1 == 1547)), 32'd1);
        wait_tick_d(2000, n);
        check("d_interval", 32'((n == 1546) || (n == 1547)), 32'd1);

        // attenuation by 9 with sign preservation
        @(negedge clk_pixel);
        drive_d(16'h7FFF, 16'h8000, 16'h003F, 16'hFFC0);
        drive_d(16'h0400, 16'hFE00, 16'h0002, 16'hFFFF);
        check("d_level_two", 32'(level_d), 32'd2);
        wait_tick_d(2000, n);
        check("d_level_after_pop", 32'(level_d), 32'd1);

        // enable low for 10 cycles flushes; outputs and count hold
        @(negedge clk_pixel);
        enable_d = 1'b0;
        exp_q_d.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_pixel);
            check("d_dis_ready", 32'(src_ready_d), 32'd0);
        end
        check("d_dis_level", 32'(level_d), 32'd0);
        check("d_dis_tick", 32'(tick_d), 32'd0);
        check("d_dis_left_hold", 32'(left_d), 32'h003F);
        check("d_dis_right_hold", 32'(right_d), 32'hFFC0);
        check("d_dis_underrun_hold", 32'(ur_d), 32'd3);
        enable_d = 1'b1;
        wait_tick_d(2000, n);
        check("d_reenable_tick_edge", 32'(n), 32'd1547);
        check("d_reenable_underrun", 32'(ur_d), 32'd4);

        // reset pulse mid-stream clears everything
        @(negedge clk_pixel);
        drive_d(16'h1000, 16'h1000, 16'h0008, 16'h0008);
        check("d_level_one", 32'(level_d), 32'd1);
        rst_n_d = 1'b0;
        #1;
        check("d_rstp_level", 32'(level_d), 32'd0);
        check("d_rstp_left", 32'(left_d), 32'd0);
        check("d_rstp_right", 32'(right_d), 32'd0);
        check("d_rstp_underrun", 32'(ur_d), 32'd0);
        check("d_rstp_ready", 32'(src_ready_d), 32'd0);
        exp_q_d.delete();
        last_d   = 32'h0;
        exp_ur_d = 16'h0;
        @(negedge clk_pixel);
        rst_n_d = 1'b1;
        wait_tick_d(2000, n);
        check("d_rstp_tick_edge", 32'(n), 32'd1547);
    endtask

    // ---------------- small-rate scenarios ----------------
    task automatic run_s();
        int n;
        int cnt;
        int last_k;
        int tick_at[4];
        tick_at = '{8, 15, 22, 29};
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        check("s_rst_ready", 32'(src_ready_s), 32'd0);
        check("s_rst_level", 32'(level_s), 32'd0);
        rst_n_s = 1'b1;

        // order: four pairs fill the FIFO
        drive_s(16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
        drive_s(16'h0002, 16'hFFFE, 16'h0002, 16'hFFFE, 1'b0);
        drive_s(16'h0003, 16'hFFFD, 16'h0003, 16'hFFFD, 1'b0);
        drive_s(16'h0004, 16'hFFFC, 16'h0004, 16'hFFFC, 1'b0);
        check("s_full_level", 32'(level_s), 32'd4);
        check("s_full_ready", 32'(src_ready_s), 32'd0);
        src_valid_s = 1'b1;
        src_left_s  = 16'h0005;
        src_right_s = 16'hFFFB;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        check("s_full_hold", 32'(level_s), 32'd4);
        src_valid_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick_s(20, n);
            check("s_drain_edge", 32'(cyc_s), 32'(tick_at[i]));
            check("s_drain_level", 32'(level_s), 32'(3 - i));
        end

        // collision at level 0: underrun, pair still lands
        @(negedge clk_pixel);
        drive_s(16'h0123, 16'hFEDC, 16'h0123, 16'hFEDC, 1'b1);
        check("s_coll0_edge", 32'(cyc_s), 32'd36);
        check("s_coll0_level", 32'(level_s), 32'd1);
        check("s_coll0_underrun", 32'(ur_s), 32'd1);
        wait_tick_s(20, n);
        check("s_coll0_pop_edge", 32'(cyc_s), 32'd43);
        check("s_coll0_drained", 32'(level_s), 32'd0);

        // collision at level 2: level unchanged, order preserved
        @(negedge clk_pixel);
        drive_s(16'h0A0A, 16'hF0F0, 16'h0A0A, 16'hF0F0, 1'b0);
        drive_s(16'h0B0B, 16'h8001, 16'h0B0B, 16'h8001, 1'b0);
        check("s_coll2_pre", 32'(level_s), 32'd2);
        drive_s(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);
        check("s_coll2_edge", 32'(cyc_s), 32'd50);
        check("s_coll2_level", 32'(level_s), 32'd2);
        wait_tick_s(20, n);
        check("s_coll2_level_b", 32'(level_s), 32'd1);
        wait_tick_s(20, n);
        check("s_coll2_level_c", 32'(level_s), 32'd0);

        // cadence: 500 enabled edges give exactly 70 ticks, 7 or 8 apart
        @(negedge clk_pixel);
        enable_s = 1'b0;
        #1;
        check("s_dis_ready", 32'(src_ready_s), 32'd0);
        @(negedge clk_pixel);
        enable_s = 1'b1;
        cnt    = 0;
        last_k = 0;
        for (int k = 1; k <= 500; k++) begin
            @(posedge clk_pixel);
            #1;
            if (tick_s === 1'b1) begin
                cnt++;
                if (cnt == 1) check("s_restart_edge", 32'(k), 32'd8);
                else check("s_interval", 32'(((k - last_k) == 7) || ((k - last_k) == 8)), 32'd1);
                last_k = k;
            end
        end
        check("s_tick_count", 32'(cnt), 32'd70);
    endtask

    // ---------------- sequencing and report ----------------
    initial begin
        fork
            run_d();
            run_s();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
